// File: rtl/alu_pkg.sv
// Shared ALU arithmetic definitions: default widths, sequencer states
// and the add/sub signed-overflow rule.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_DIGIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    // Add overflows on like signs, sub on unlike signs, when the result sign differs from A.
    function automatic logic arith_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb,
        input logic is_sub
    );
        return (a_msb ^ b_msb ^ ~is_sub) & (r_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational W-bit subtract slice with borrow in/out.
// Reused every cycle by the serial subtractor.
module digit_subtractor #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic [W-1:0] d_o,
    output logic         bout_o
);

    logic [W:0] full;

    assign full   = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
    assign d_o    = full[W-1:0];
    assign bout_o = full[W];

endmodule

// File: rtl/serial_subtractor_32bit.sv
// Multi-cycle A - B - borrow_in, DIGIT bits per clock, LSD first.
// Result and flags are registered on the final digit cycle only.
module serial_subtractor_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DIGIT = ALU_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    input  logic             signed_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("DIGIT must divide WIDTH exactly");
    end

    sub_state_e state_q;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             sgn_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             zero_q;

    logic [DIGIT-1:0]       dig;
    logic                   bout;
    logic [WIDTH+DIGIT-1:0] cat;
    logic                   last;

    digit_subtractor #(
        .W(DIGIT)
    ) u_dig (
        .a_i   (a_q[DIGIT-1:0]),
        .b_i   (b_q[DIGIT-1:0]),
        .bin_i (br_q),
        .d_o   (dig),
        .bout_o(bout)
    );

    // New digit enters at the top; after NDIG shifts it sits in place.
    assign cat   = {dig, res_q};
    assign res_d = cat[WIDTH+DIGIT-1:DIGIT];
    assign last  = (cnt_q == CW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            sgn_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    busy_q <= start;
                    if (start) begin
                        state_q <= ST_RUN;
                        a_q     <= A;
                        b_q     <= B;
                        br_q    <= borrow_in;
                        sgn_q   <= signed_op;
                        a_msb_q <= A[WIDTH-1];
                        b_msb_q <= B[WIDTH-1];
                        cnt_q   <= '0;
                        res_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    res_q <= res_d;
                    br_q  <= bout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        diff_q   <= res_d;
                        borrow_q <= bout;
                        zero_q   <= (res_d == '0);
                        ovf_q    <= sgn_q & arith_overflow(a_msb_q, b_msb_q,
                                                           res_d[WIDTH-1], 1'b1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Bench for serial_subtractor_32bit at DIGIT = 4, 1 and 8.
// Directed handshake/flag cases plus a randomized regression.
module tb_serial_subtractor_32bit;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } res_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic [31:0] A         = '0;
    logic [31:0] B         = '0;
    logic        borrow_in = 1'b0;
    logic        signed_op = 1'b0;

    logic        busy       [3];
    logic        done       [3];
    logic [31:0] diff       [3];
    logic        borrow_out [3];
    logic        overflow   [3];
    logic        zero       [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_subtractor_32bit #(
            .WIDTH(32),
            .DIGIT((g == 0) ? 4 : (g == 1) ? 1 : 8)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .A         (A),
            .B         (B),
            .borrow_in (borrow_in),
            .signed_op (signed_op),
            .busy      (busy[g]),
            .done      (done[g]),
            .diff      (diff[g]),
            .borrow_out(borrow_out[g]),
            .overflow  (overflow[g]),
            .zero      (zero[g])
        );
    end

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic bi, input logic so);
        res_t   r;
        longint u;
        longint s;
        u = longint'({32'b0, a}) - longint'({32'b0, b}) - longint'({63'b0, bi});
        s = longint'($signed(a)) - longint'($signed(b)) - longint'({63'b0, bi});
        r.d  = u[31:0];
        r.bo = (u < 0);
        r.ov = so && ((s > longint'(64'sh7FFF_FFFF)) ||
                      (s < -longint'(64'sh8000_0000)));
        r.z  = (r.d == 32'h0);
        return r;
    endfunction

    function automatic res_t got(input int g);
        return {diff[g], borrow_out[g], overflow[g], zero[g]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input logic so,
                          output int lat, output int busy_n);
        A = a;
        B = b;
        borrow_in = bi;
        signed_op = so;
        start = 1'b1;
        busy_n = 0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done[0] && lat < 60) begin
            if (busy[0]) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if ({busy[g], done[g], got(g)} !== 37'h0) begin
                n_fail++;
                $display("FAIL reset_async[%0d]: got %h expected 0", g,
                         {busy[g], done[g], got(g)});
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy[0], done[0], got(0)} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 0", {busy[0], done[0], got(0)});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        int bn;
        run_op(32'd5, 32'd3, 1'b0, 1'b0, lat, bn);
        n_tests++;
        if (lat !== 9 || bn !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got lat %0d busy %0d expected 9 and 8", lat, bn);
        end
        n_tests++;
        if (got(0) !== {32'h2, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got %h expected %h", got(0),
                     {32'h2, 1'b0, 1'b0, 1'b0});
        end
        @(posedge clk); #1;
        n_tests++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: got done %b busy %b expected 0 0", done[0], busy[0]);
        end
    endtask

    task automatic test_flags();
        logic [31:0] ta [6] = '{32'h0, 32'h1234_5678, 32'h1234_5678,
                                32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
        logic [31:0] tb [6] = '{32'h1, 32'h1234_5678, 32'h1234_5678,
                                32'h1, 32'hFFFF_FFFF, 32'h5};
        logic        tbi [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        tso [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        res_t        te [6] = '{{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
                                {32'h0000_0000, 1'b0, 1'b0, 1'b1},
                                {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
                                {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
                                {32'h8000_0000, 1'b1, 1'b1, 1'b0},
                                {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0}};
        int lat;
        int bn;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], tbi[i], tso[i], lat, bn);
            n_tests++;
            if (lat !== 9 || got(0) !== te[i]) begin
                n_fail++;
                $display("FAIL flags_case%0d: got %h lat %0d expected %h lat 9",
                         i, got(0), lat, te[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int bn;
        int extra;
        run_op(32'd10, 32'd3, 1'b0, 1'b0, lat, bn);
        A = 32'd100;
        B = 32'd1;
        borrow_in = 1'b0;
        signed_op = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done[0] && lat < 60) begin
            if (lat == 3) begin
                n_tests++;
                if (diff[0] !== 32'd7) begin
                    n_fail++;
                    $display("FAIL hold_during_run: got %h expected %h", diff[0], 32'd7);
                end
                A = 32'd55;
                B = 32'd44;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_tests++;
        if (lat !== 9 || got(0) !== {32'd99, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL start_in_run: got %h lat %0d expected %h lat 9",
                     got(0), lat, {32'd99, 1'b0, 1'b0, 1'b0});
        end
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done[0] || busy[0]) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL no_queue: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] oa [4];
        logic [31:0] ob [4];
        logic        obi [4];
        logic        oso [4];
        int          early;
        for (int k = 0; k < 4; k++) begin
            oa[k]  = $urandom;
            ob[k]  = $urandom;
            obi[k] = 1'($urandom_range(1));
            oso[k] = 1'($urandom_range(1));
        end
        A = oa[0];
        B = ob[0];
        borrow_in = obi[0];
        signed_op = oso[0];
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            early = 0;
            for (int c = 1; c <= 8; c++) begin
                A = $urandom;
                B = $urandom;
                borrow_in = 1'($urandom_range(1));
                signed_op = 1'($urandom_range(1));
                @(posedge clk); #1;
                if (c < 8 && done[0]) early++;
            end
            n_tests++;
            if (done[0] !== 1'b1 || early !== 0) begin
                n_fail++;
                $display("FAIL b2b_done%0d: got done %b early %0d expected 1 0",
                         k, done[0], early);
            end
            n_tests++;
            if (got(0) !== model(oa[k], ob[k], obi[k], oso[k])) begin
                n_fail++;
                $display("FAIL b2b_res%0d: got %h expected %h", k, got(0),
                         model(oa[k], ob[k], obi[k], oso[k]));
            end
            if (k < 3) begin
                A = oa[k+1];
                B = ob[k+1];
                borrow_in = obi[k+1];
                signed_op = oso[k+1];
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int          lat;
        int          bn;
        logic [31:0] a;
        logic [31:0] b;
        run_op(32'd9, 32'd2, 1'b0, 1'b0, lat, bn);
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy[0], done[0], got(0)} !== 37'h0) begin
            n_fail++;
            $display("FAIL rst_midop: got %h expected 0", {busy[0], done[0], got(0)});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a = $urandom;
        b = $urandom;
        run_op(a, b, 1'b1, 1'b1, lat, bn);
        n_tests++;
        if (lat !== 9 || got(0) !== model(a, b, 1'b1, 1'b1)) begin
            n_fail++;
            $display("FAIL rst_fresh: got %h lat %0d expected %h lat 9",
                     got(0), lat, model(a, b, 1'b1, 1'b1));
        end
    endtask

    task automatic test_random();
        int   lat;
        int   ldone [3];
        int   lexp  [3] = '{9, 33, 5};
        res_t e;
        repeat (40) @(posedge clk);
        #1;
        for (int it = 0; it < 1000; it++) begin
            A = $urandom;
            B = $urandom;
            if (it % 8 == 0) B = A;
            borrow_in = 1'($urandom_range(1));
            signed_op = 1'($urandom_range(1));
            e = model(A, B, borrow_in, signed_op);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            A = $urandom;
            B = $urandom;
            lat = 1;
            ldone = '{0, 0, 0};
            while (ldone[1] == 0 && lat < 60) begin
                for (int g = 0; g < 3; g++)
                    if (ldone[g] == 0 && done[g]) ldone[g] = lat;
                if (ldone[1] == 0) begin
                    @(posedge clk); #1;
                    lat++;
                end
            end
            for (int g = 0; g < 3; g++) begin
                n_tests++;
                if (ldone[g] !== lexp[g] || got(g) !== e) begin
                    n_fail++;
                    $display("FAIL rand%0d_dig%0d: got %h lat %0d expected %h lat %0d",
                             it, g, got(g), ldone[g], e, lexp[g]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_start_ignored();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/serial_subtractor_32bit.md
Name: serial_subtractor_32bit

Overview:
- Multi-cycle subtractor: computes A - B - borrow_in, DIGIT bits per clock, least-significant digit first.
- Companion to the single-cycle 32-bit carry adder in the ALU arithmetic path; used where area matters more than latency.
- start/busy/done handshake; result flags (borrow, signed overflow, zero) are registered at completion.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- NDIG, WIDTH/DIGIT, derived digit count; sets latency.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE or DONE.
- A  in  WIDTH  minuend; sampled on accepted start.
- B  in  WIDTH  subtrahend; sampled on accepted start.
- borrow_in  in  1  incoming borrow; sampled on accepted start.
- signed_op  in  1  1 = two's-complement overflow detection; sampled on accepted start.
- busy  out  1  high while RUN.
- done  out  1  one-cycle pulse; result valid.
- diff  out  WIDTH  A - B - borrow_in mod 2^WIDTH.
- borrow_out  out  1  1 when unsigned A < B + borrow_in.
- overflow  out  1  signed overflow; forced 0 when signed_op = 0.
- zero  out  1  diff == 0.

Behaviour:
- Reset: asynchronous on rst_n low. State returns to IDLE. busy, done, diff, borrow_out, overflow, zero and all internal registers clear to 0. Applies at any time, including mid-operation; the in-flight operation is discarded.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE after NDIG digit cycles.
  - DONE -> RUN on start, else DONE -> IDLE.
- Accepted start (IDLE or DONE):
  - Latch A, B, borrow_in and signed_op into shift registers.
  - Digit counter = 0; busy = 1 on the next cycle.
- RUN, each cycle:
  - Compute {bout, d} = a[DIGIT-1:0] - b[DIGIT-1:0] - br.
  - br is the running borrow, initialised from borrow_in.
  - Shift the a and b registers right by DIGIT.
  - Shift d into the top of the result register; br <= bout.
  - Increment the counter.
  - Save the sign bits of the latched A and B for the overflow calculation.
- Completion:
  - On the NDIG-th RUN cycle, the registers update at the clock edge: diff, borrow_out = final br, zero = (result == 0), overflow = signed_op & (A[W-1] ^ B[W-1]) & (diff[W-1] ^ A[W-1]).
  - In that same cycle, state -> DONE and done = 1 for exactly one cycle; busy = 0 in DONE.
- Latency: done asserts NDIG+1 cycles after the accepting start edge (9 cycles at the defaults). Throughput: one operation per NDIG+1 cycles when start is held.
- Output stability: diff and the flags hold their last value until the next completion. They do not change during RUN.
- start during RUN: ignored, no queuing.
- start in the DONE cycle: accepted; done still pulses for the finished op.
- borrow_in = 1 with A = B: diff = all ones, borrow_out = 1, zero = 0.
- Operands change after an accepted start: no effect.

Decomposition:
- Shared package (alu_pkg):
  - State encoding IDLE/RUN/DONE as a 2-bit typedef.
  - Default WIDTH and DIGIT constants.
  - Overflow-rule helper, shared with the adder's add/sub overflow logic.
- Natural sub-module: digit_subtractor. Combinational DIGIT-bit slice; inputs a, b, bin; outputs d, bout. Instantiated once and reused each cycle.

Test Plan:
1. A=5, B=3, borrow_in=0, signed_op=0; start for 1 cycle -> busy for 8 cycles; done on cycle 9 with diff=0x00000002, borrow_out=0, zero=0, overflow=0.
2. A=0, B=1, signed_op=0 -> diff=0xFFFFFFFF, borrow_out=1, overflow=0. Repeat with A=B=0x12345678, borrow_in=0 -> diff=0, zero=1. Same operands with borrow_in=1 -> diff=0xFFFFFFFF, borrow_out=1.
3. signed_op=1, A=0x80000000, B=1 -> diff=0x7FFFFFFF, overflow=1, borrow_out=0. Then A=0x7FFFFFFF, B=0xFFFFFFFF -> diff=0x80000000, overflow=1. Then A=3, B=5 -> diff=0xFFFFFFFE, overflow=0.
4. Handshake ordering:
   - start pulsed on cycle 3 of RUN with different operands -> ignored; result matches the first op.
   - start held high continuously -> done every 9 cycles; each result uses the operands present at the accepting edge.
5. Reset mid-op: drop rst_n asynchronously during cycle 4 of RUN -> all outputs 0 immediately, state IDLE. A subsequent start gives a correct fresh result; no stale digits.
6. Random regression: 1000 random A, B, borrow_in, signed_op, with DIGIT=4 and again with DIGIT=1 and DIGIT=8 -> all outputs match a reference model; done latency = WIDTH/DIGIT + 1.
